// File: rtl/sqr.sv
// Shift-add squarer: result = A*A after a one-cycle load and up to 16 add/shift steps.
// Define SQR_EARLY_DONE_EN to finish as soon as no multiplier bits remain.
module sqr (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [15:0] A,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        init_q;
    logic        start;
    logic [31:0] acc;
    logic [31:0] acc_nx;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  count;

    assign start = init & ~init_q;

    always_comb begin
        state_nx = state;
        acc_nx   = mplier[0] ? (acc + mcand) : acc;
        case (state)
            IDLE, DONE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
`ifdef SQR_EARLY_DONE_EN
                state_nx = (A == 16'd0) ? DONE : ITER;
`else
                state_nx = ITER;
`endif
            end
            ITER: begin
                if (count == 4'd15) state_nx = DONE;
`ifdef SQR_EARLY_DONE_EN
                // Post-iteration multiplier is mplier>>1; nothing left to add once it is zero.
                else if (mplier[15:1] == 15'd0) state_nx = DONE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            init_q <= 1'b0;
            acc    <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 16'd0;
            count  <= 4'd0;
            result <= 32'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            init_q <= init;
            case (state)
                IDLE, DONE: begin
                    // result is kept until the next operation overwrites it
                    if (start) done <= 1'b0;
                end
                LOAD: begin
                    acc    <= 32'd0;
                    mcand  <= {16'd0, A};
                    mplier <= A;
                    count  <= 4'd0;
`ifdef SQR_EARLY_DONE_EN
                    if (A == 16'd0) begin
                        result <= 32'd0;
                        done   <= 1'b1;
                    end
`endif
                end
                ITER: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 4'd1;
                    if (state_nx == DONE) begin
                        result <= acc_nx;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqr.sv
// Randomized bench for sqr: reference model is plain A*A plus a latency rule
// derived from the operand; an expected-result queue is drained on each done.
module tb_sqr;

    logic        clk;
    logic        rst;
    logic        init;
    logic [15:0] A;
    logic [31:0] result;
    logic        done;

    logic [31:0] exp_q[$];
    logic [31:0] model_result;
    int          n_vec;
    int          n_err;

    sqr dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .A      (A),
        .result (result),
        .done   (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: cycles from the start edge to the edge where done rises
    function automatic int exp_latency(input logic [15:0] a);
        int lat;
        lat = 17;
`ifdef SQR_EARLY_DONE_EN
        if (a == 16'd0) lat = 1;
        else
            for (int b = 0; b < 16; b++)
                if (a[b]) lat = 2 + b;
`endif
        return lat;
    endfunction

    function automatic logic [31:0] exp_square(input logic [15:0] a);
        logic [31:0] wide;
        wide = {16'd0, a};
        return wide * wide;
    endfunction

    // driver: one full operation; hold = cycles init stays high, repulse = extra start attempt
    task automatic run_op(input logic [15:0] a, input int hold, input int repulse, input bit through_rst);
        int k;
        int lat;
        lat = exp_latency(a);
        A   = a;
        if (through_rst) begin
            rst  = 1'b1;
            init = 1'b1;
            tick();
            tick();
            model_result = 32'd0;
            check("rst_hold_done", {31'd0, done}, 32'd0);
            check("rst_hold_result", result, 32'd0);
            rst = 1'b0;
        end
        init = 1'b1;
        exp_q.push_back(exp_square(a));
        tick();  // edge N
        check("start_done_clear", {31'd0, done}, 32'd0);
        check("start_result_held", result, model_result);
        for (k = 1; k <= 40; k++) begin
            init = (k < hold) || (k == repulse);
            if (k >= 2) A = 16'($urandom);
            tick();
            if (done) break;
            check("busy_result_held", result, model_result);
        end
        check("latency", k, lat);
        check("result", result, exp_q.pop_front());
        model_result = exp_square(a);
        init = 1'b0;
        for (int j = 0; j < 3; j++) begin
            A = 16'($urandom);
            tick();
            check("done_stays", {31'd0, done}, 32'd1);
            check("result_stays", result, model_result);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_result = 32'd0;
        rst  = 1'b1;
        init = 1'b0;
        A    = 16'd0;
        tick();
        tick();
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        tick();

        run_op(16'h0441, 2, 0, 1'b0);
        run_op(16'hFFFF, 1, 0, 1'b0);
        run_op(16'h0000, 1, 0, 1'b0);
        run_op(16'h0001, 1, 0, 1'b0);
        run_op(16'h0441, 1, 5, 1'b0);
        run_op(16'h0002, 1, 0, 1'b0);
        run_op(16'h0441, 1, 0, 1'b0);

        // abort an operation with rst at N+8
        A    = 16'hFFFF;
        init = 1'b1;
        tick();  // edge N
        init = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();  // edge N+8
        model_result = 32'd0;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_op(16'h0010, 1, 0, 1'b0);

        // init held high across rst release
        run_op(16'h1234, 3, 0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if (i % 5 == 0) a = a >> $urandom_range(15, 0);
            run_op(a, $urandom_range(4, 1), $urandom_range(20, 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
